// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
package forwarding_scoreboard_pkg;

  localparam int unsigned REG_W_DEF = 4;
  localparam int unsigned REG_W_MAX = 8;

  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned FWD_MEM = 1;
  localparam int unsigned FWD_WB  = 2;

  // Destination is stored at the widest supported register address width
  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [REG_W_MAX-1:0] dest;
    logic                 is_load;
  } slot_t;

endpackage

// File: rtl/forwarding_scoreboard_prio.sv
// Per-operand priority encoder: the youngest forwardable producer wins.
module fwd_match_prio
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [DEPTH-1:0] hit,
  output logic [SEL_W-1:0] sel_c
);

  // hit[k-1] corresponds to slot k; scan oldest to youngest so the youngest overrides
  always_comb begin
    sel_c = SEL_W'(FWD_RF);
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (hit[k-1]) sel_c = SEL_W'(k);
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// DEPTH-deep shadow pipeline producing Exe forwarding selects and a Reg-stage load-use stall.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LOAD_LAT    = 1,
  parameter bit          ZERO_REG_EN = 1'b0,
  localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [N_SRC*REG_W-1:0] dec_src,
  input  logic [N_SRC-1:0]       dec_src_re,
  input  logic                   dec_we,
  input  logic [REG_W-1:0]       dec_dest,
  input  logic                   dec_is_load,
  input  logic                   flush,
  output logic [N_SRC*SEL_W-1:0] fwd_sel,
  output logic                   stall,
  output logic [15:0]            stall_count
);

  slot_t                         slots [0:DEPTH];
  logic [N_SRC-1:0][REG_W-1:0]   s0_src;
  logic [N_SRC-1:0]              s0_re;
  logic [N_SRC-1:0][REG_W-1:0]   dsrc;
  logic [N_SRC-1:0][DEPTH-1:0]   hit;
  logic [N_SRC-1:0]              op_found;
  logic [N_SRC-1:0]              op_hazard;

  assign dsrc = dec_src;

  function automatic logic match(input slot_t s, input logic [REG_W-1:0] a);
    return s.valid && s.we && (s.dest == REG_W_MAX'(a)) && !(ZERO_REG_EN && (a == '0));
  endfunction

  function automatic logic ready(input slot_t s, input int unsigned k);
    return !s.is_load || (k >= 1 + LOAD_LAT);
  endfunction

  // Forwarding candidates for each Exe operand, one bit per slot 1..DEPTH
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        hit[i][k-1] = s0_re[i] && match(slots[k], s0_src[i]) && ready(slots[k], k);
      end
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_op
    fwd_match_prio #(
      .DEPTH(DEPTH),
      .SEL_W(SEL_W)
    ) u_prio (
      .hit  (hit[i]),
      .sel_c(fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  // Only the youngest producer of each operand decides whether the Reg stage must wait
  always_comb begin
    op_found  = '0;
    op_hazard = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (dec_src_re[i] && !op_found[i] && match(slots[k], dsrc[i])) begin
          op_found[i]  = 1'b1;
          op_hazard[i] = slots[k].is_load && (k < LOAD_LAT);
        end
      end
    end
  end

  assign stall = dec_valid && !flush && (|op_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= DEPTH; k++) slots[k] <= '0;
      s0_src      <= '0;
      s0_re       <= '0;
      stall_count <= '0;
    end else begin
      for (int unsigned k = DEPTH; k >= 1; k--) slots[k] <= slots[k-1];
      if (stall || flush) begin
        slots[0] <= '0;
        s0_src   <= '0;
        s0_re    <= '0;
      end else begin
        slots[0] <= '{valid: dec_valid, we: dec_we, dest: REG_W_MAX'(dec_dest), is_load: dec_is_load};
        s0_src   <= dsrc;
        s0_re    <= dec_src_re;
      end
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: instruction-history model plus directed pipeline scenarios.
module tb_forwarding_scoreboard;

  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dec_valid = 1'b0;
  logic [7:0] dec_src = '0;
  logic [1:0] dec_src_re = '0;
  logic       dec_we = 1'b0;
  logic [3:0] dec_dest = '0;
  logic       dec_is_load = 1'b0;
  logic       flush = 1'b0;

  logic [3:0]  f_fwd, z_fwd;
  logic        f_stall, z_stall;
  logic [15:0] f_cnt, z_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  forwarding_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_re(dec_src_re), .dec_we(dec_we), .dec_dest(dec_dest),
    .dec_is_load(dec_is_load), .flush(flush),
    .fwd_sel(f_fwd), .stall(f_stall), .stall_count(f_cnt)
  );

  forwarding_scoreboard #(.ZERO_REG_EN(1'b1)) dut_z (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_re(dec_src_re), .dec_we(dec_we), .dec_dest(dec_dest),
    .dec_is_load(dec_is_load), .flush(flush),
    .fwd_sel(z_fwd), .stall(z_stall), .stall_count(z_cnt)
  );

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of issued instructions, index = age (0 = currently in Exe)
  typedef struct packed {
    logic v, we, ld;
    logic [3:0] dest;
    logic [1:0][3:0] src;
    logic [1:0] re;
  } ent_t;

  ent_t q_f[$];
  ent_t q_z[$];
  int   m_cnt_f, m_cnt_z;

  function automatic bit produces(input ent_t e, input logic [3:0] a, input bit z);
    return e.v && e.we && (e.dest == a) && !(z && (a == 4'd0));
  endfunction

  // A load aged `age` reaches the forwardable point (age 1+LOAD_LAT) too late for a consumer entering Exe next cycle
  function automatic bit m_stall(input ent_t q[$], input bit z);
    logic [1:0][3:0] s;
    s = dec_src;
    if (!dec_valid || flush) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (dec_src_re[i]) begin
        for (int age = 0; age < int'(DEPTH); age++) begin
          if (produces(q[age], s[i], z)) begin
            if (q[age].ld && ((1 + int'(LOAD_LAT)) - (age + 1) > 0)) return 1'b1;
            break;
          end
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(input ent_t q[$], input int i, input bit z);
    if (!q[0].re[i]) return 0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if (produces(q[k], q[0].src[i], z) && (!q[k].ld || k >= 1 + int'(LOAD_LAT))) return k;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_f = {};
      q_z = {};
      for (int k = 0; k <= int'(DEPTH); k++) begin
        q_f.push_back('0);
        q_z.push_back('0);
      end
      m_cnt_f = 0;
      m_cnt_z = 0;
    end else begin
      ent_t cur;
      bit sf, sz;
      cur = '{v: dec_valid, we: dec_we, ld: dec_is_load, dest: dec_dest, src: dec_src, re: dec_src_re};
      sf = m_stall(q_f, 1'b0);
      sz = m_stall(q_z, 1'b1);
      if (sf && m_cnt_f < 65535) m_cnt_f++;
      if (sz && m_cnt_z < 65535) m_cnt_z++;
      void'(q_f.pop_back());
      void'(q_z.pop_back());
      q_f.push_front((sf || flush) ? ent_t'('0) : cur);
      q_z.push_front((sz || flush) ? ent_t'('0) : cur);
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      cmp("model_fwd", int'(f_fwd), m_fwd(q_f, 1, 1'b0) * 4 + m_fwd(q_f, 0, 1'b0));
      cmp("model_stall", int'(f_stall), int'(m_stall(q_f, 1'b0)));
      cmp("model_count", int'(f_cnt), m_cnt_f);
      cmp("model_fwd_z", int'(z_fwd), m_fwd(q_z, 1, 1'b1) * 4 + m_fwd(q_z, 0, 1'b1));
      cmp("model_stall_z", int'(z_stall), int'(m_stall(q_z, 1'b1)));
      cmp("model_count_z", int'(z_cnt), m_cnt_z);
    end
  end

  // Present one instruction in Reg, holding it while either instance stalls
  task automatic issue(input bit v, input bit we, input bit ld, input int dst,
                       input int s0, input int s1, input logic [1:0] re, input bit fl,
                       output int ns, output int nz);
    bit done;
    dec_valid   = v;
    dec_we      = we;
    dec_is_load = ld;
    dec_dest    = 4'(dst);
    dec_src     = {4'(s1), 4'(s0)};
    dec_src_re  = re;
    flush       = fl;
    ns = 0;
    nz = 0;
    done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (f_stall) ns++;
      if (z_stall) nz++;
      if (!f_stall && !z_stall) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) cmp("stall_timeout", 1, 0);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic nop(input int n);
    int a, b;
    for (int j = 0; j < n; j++) issue(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00, 1'b0, a, b);
  endtask

  initial begin
    int ns, nz;
    int exp_gap[3] = '{2, 3, 0};
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    #2;
    cmp("reset_fwd", int'(f_fwd), 0);
    cmp("reset_stall", int'(f_stall), 0);
    cmp("reset_count", int'(f_cnt), 0);

    // ADD R1 ; ST reads R1 as src1
    issue(1, 1, 0, 1, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 0, 0, 0, 2, 1, 2'b10, 0, ns, nz);
    cmp("st_stall", ns, 0);
    #2;
    cmp("st_fwd_src1", int'(f_fwd[3:2]), 1);
    cmp("st_fwd_src0", int'(f_fwd[1:0]), 0);
    nop(4);

    // ADD R1, n NOPs, SUB R2,R1,R3
    for (int g = 1; g <= 3; g++) begin
      issue(1, 1, 0, 1, 0, 0, 2'b00, 0, ns, nz);
      nop(g);
      issue(1, 1, 0, 2, 1, 3, 2'b11, 0, ns, nz);
      #2;
      cmp($sformatf("gap%0d_fwd_src0", g), int'(f_fwd[1:0]), exp_gap[g-1]);
      nop(4);
    end

    // LD R4 ; ADD R5,R4,R4 back to back
    cmp("ld_use_count_before", int'(f_cnt), 0);
    issue(1, 1, 1, 4, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 1, 0, 5, 4, 4, 2'b11, 0, ns, nz);
    cmp("ld_use_stall_cycles", ns, 1);
    #2;
    cmp("ld_use_fwd", int'(f_fwd), 4'b1010);
    cmp("ld_use_count_after", int'(f_cnt), 1);
    nop(4);

    // LD R4 ; ADD R4 ; use R4 -> younger ALU result shadows the load
    issue(1, 1, 1, 4, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 1, 0, 4, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 0, 0, 0, 4, 0, 2'b01, 0, ns, nz);
    cmp("shadow_stall_cycles", ns, 0);
    #2;
    cmp("shadow_fwd", int'(f_fwd[1:0]), 1);
    nop(4);

    // LD R6 ; consumer flushed ; consumer reissued
    issue(1, 1, 1, 6, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 0, 0, 0, 6, 0, 2'b01, 1, ns, nz);
    cmp("flush_stall_cycles", ns, 0);
    #2;
    cmp("flush_bubble_fwd", int'(f_fwd), 0);
    issue(1, 0, 0, 0, 6, 0, 2'b01, 0, ns, nz);
    cmp("after_flush_stall_cycles", ns, 0);
    #2;
    cmp("after_flush_fwd", int'(f_fwd[1:0]), 2);
    nop(4);

    // Register 0 with and without the zero-register rule
    issue(1, 1, 0, 0, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 0, 0, 0, 0, 0, 2'b01, 0, ns, nz);
    #2;
    cmp("r0_fwd_zero_en", int'(z_fwd[1:0]), 0);
    cmp("r0_fwd_plain", int'(f_fwd[1:0]), 1);
    nop(4);
    issue(1, 1, 1, 0, 0, 0, 2'b00, 0, ns, nz);
    issue(1, 0, 0, 0, 0, 0, 2'b01, 0, ns, nz);
    cmp("r0_load_stall_plain", ns, 1);
    cmp("r0_load_stall_zero_en", nz, 0);
    nop(4);

    // Reset asserted in the middle of a load-use stall
    issue(1, 1, 1, 7, 0, 0, 2'b00, 0, ns, nz);
    dec_valid = 1'b1; dec_we = 1'b0; dec_is_load = 1'b0; dec_dest = 4'd0;
    dec_src = {4'd0, 4'd7}; dec_src_re = 2'b01; flush = 1'b0;
    @(negedge clk);
    cmp("pre_rst_stall", int'(f_stall), 1);
    cmp("pre_rst_stall_z", int'(z_stall), 1);
    #1 rst = 1'b1;
    #1;
    cmp("rst_stall", int'(f_stall), 0);
    cmp("rst_stall_z", int'(z_stall), 0);
    cmp("rst_count", int'(f_cnt), 0);
    cmp("rst_count_z", int'(z_cnt), 0);
    @(posedge clk);
    #1;
    dec_valid = 1'b0; dec_src_re = 2'b00;
    rst = 1'b0;
    nop(4);
    cmp("post_rst_count", int'(f_cnt), 0);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised next-generation forwarding/hazard unit for the filter processor pipeline.
- Keeps its own shadow record of every in-flight instruction from Exe to the last write-back stage.
- Generates per-operand forwarding selects for the Exe stage and a load-use stall for the Reg stage.
- Replaces hard-wired Mem/WB comparisons with a DEPTH-deep scoreboard, N_SRC operands, configurable load latency and flush support.

Parameters:
- REG_W, 4, register address width.
- N_SRC, 2, source operands per instruction; the store-data operand is one of these.
- DEPTH, 3, forwarding stages after Exe; slot 1 = Mem, slot DEPTH = last WB stage.
- LOAD_LAT, 1, extra cycles before a load result can be forwarded (1 <= LOAD_LAT < DEPTH).
- ZERO_REG_EN, 0, when 1, register 0 never matches (never forwarded, never stalls).
- SEL_W, clog2(DEPTH+1), width of each forwarding select (derived, not overridden).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- dec_valid, in, 1, Reg-stage instruction valid.
- dec_src, in, N_SRC*REG_W, Reg-stage source addresses; operand i at [i*REG_W +: REG_W].
- dec_src_re, in, N_SRC, per-operand read enable.
- dec_we, in, 1, Reg-stage instruction writes a register.
- dec_dest, in, REG_W, destination address.
- dec_is_load, in, 1, instruction is a memory load.
- flush, in, 1, squash the Reg-stage instruction (branch taken).
- fwd_sel, out, N_SRC*SEL_W, Exe operand source: 0 = register file, k = slot k.
- stall, out, 1, hold PC and the Reg stage this cycle.
- stall_count, out, 16, saturating count of stall cycles.

Behaviour:
- State: slot[0..DEPTH], each holding {valid, we, dest, is_load}. Slot 0 is Exe and additionally holds src[N_SRC] and re[N_SRC].
- Reset (asynchronous): all slot valids 0, stall_count 0. Outputs therefore read fwd_sel = 0 and stall = 0.
- Every clock, slot k shifts to slot k+1 for k = 0..DEPTH-1; slot DEPTH retires.
- Slot 0 loading:
  - If stall or flush is high, slot 0 loads a bubble (valid = 0).
  - Otherwise slot 0 captures the dec_* inputs, with valid = dec_valid.
- Flush does not disturb slots 1..DEPTH.
- Match(k, a): slot[k].valid & slot[k].we & slot[k].dest == a, and a != 0 when ZERO_REG_EN = 1.
- Readiness: a slot is forwardable when it is not a load, or when k >= 1 + LOAD_LAT.
- fwd_sel operand i (combinational from slot 0):
  - Value is the smallest k in 1..DEPTH with slot0.re[i] & Match(k, slot0.src[i]) & forwardable; otherwise 0.
  - The youngest producer wins.
  - If a matching load is not yet forwardable, fwd_sel is 0. The stall logic guarantees this case never occurs with a valid consumer.
- stall (combinational):
  - High when dec_valid & !flush and, for some operand i with dec_src_re[i], some k in 0..DEPTH-1 satisfies Match(k, dec_src[i]) & slot[k].is_load & (k+1 < 1+LOAD_LAT).
  - The youngest match decides: an older load shadowed by a younger ALU write to the same register does not stall.
- Stall duration: with LOAD_LAT = 1, one cycle; in general LOAD_LAT - k cycles.
- flush takes priority over stall; stall is 0 in any cycle where flush is 1.
- stall_count increments each cycle stall = 1 and saturates at 16'hFFFF.
- Reset asserted mid-stall: stall drops immediately and the scoreboard empties.
- All outputs are purely combinational from registered state plus dec_* inputs. There is no extra latency.

Decomposition:
- Shared package holds:
  - Slot record typedef {valid, we, dest, is_load}.
  - fwd_sel encodings: FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2.
  - Default REG_W.
- Sub-module fwd_match_prio:
  - One instance per operand.
  - Priority encoder over DEPTH match/ready bits, producing the select.

Test Plan (defaults unless stated):
- ADD R1 issued, next instruction ST reads R1 as src1 -> in its Exe cycle fwd_sel[3:2] = 2'b01, stall = 0.
- ADD R1, NOP, SUB R2,R1,R3 -> consumer's Exe fwd_sel[1:0] = 2'b10. With a second NOP added -> 2'b11. With a third NOP added -> 2'b00.
- LD R4 then ADD R5,R4,R4 back to back:
  - stall = 1 for exactly one cycle; stall_count 0 -> 1.
  - Bubble enters Exe.
  - In the consumer's Exe cycle both operand selects = 2.
- LD R4 then ADD R4 then use R4 -> no stall; use gets fwd_sel = 1 (the ADD), not the load.
- LD R4 with consumer in Reg and flush = 1 in the same cycle -> stall = 0, consumer squashed, load continues to slot 1.
- ZERO_REG_EN = 1, ADD R0 then use R0 -> fwd_sel = 0, stall never asserted. Then rst asserted mid-stall -> stall = 0 and stall_count = 0 asynchronously.
